mode_tick_control: RTL and testbench

MODE_TICK_CONTROL -- requirements
Module: mode_tick_control

---
 rtl/mode_tick_control.sv | 140 ++++++++++++++
 tb/tb_mode_tick_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_tick_control.sv
// mode_tick_control
// Two raw push buttons (mode, pause) are synchronized, debounced and edge
// detected. A mode press advances a 2-bit pattern selector and restarts the
// step prescaler. A pause press toggles the pause level that freezes the
// prescaler. The tick output is a one-cycle pulse every TICK_DIV cycles.
//
// Optional feature macro: PAUSE_CLEAR_ON_MODE_EN
//   defined   -> a mode press also forces pause=0 (wins over a coincident
//                pause toggle)
//   undefined -> a mode press leaves pause alone
//
// The reset input is asynchronous and active-low.
module mode_tick_control #(
  parameter int unsigned TICK_DIV        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic       tick,
  output logic       pause,
  output logic [1:0] mode,
  output logic       mode_chg
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PS_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  localparam int unsigned BTN_MODE  = 0;
  localparam int unsigned BTN_PAUSE = 1;

  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            acc_q, acc_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [PS_W-1:0]       ps_q, ps_d;
  logic                  tick_q, tick_d;
  logic                  pause_q, pause_d;
  logic [1:0]            mode_q, mode_d;
  logic                  mode_chg_q, mode_chg_d;

  assign btn_raw = {btn_pause, btn_mode};

  // Two-stage synchronizer for both raw buttons
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce: count while the synchronized level disagrees with the accepted
  // one; accept on the DEBOUNCE_CYCLES-th disagreeing cycle. A rising edge
  // of the accepted level becomes a one-cycle press flag.
  always_comb begin
    acc_d    = acc_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          acc_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
      press_d[i] = acc_d[i] & ~acc_q[i];
    end
  end

  // Mode selector and pause level; both presses may apply on one edge
  always_comb begin
    mode_d     = mode_q;
    pause_d    = pause_q;
    mode_chg_d = 1'b0;
    if (press_q[BTN_PAUSE]) begin
      pause_d = ~pause_q;
    end
    if (press_q[BTN_MODE]) begin
      mode_d     = mode_q + 2'd1;
      mode_chg_d = 1'b1;
`ifdef PAUSE_CLEAR_ON_MODE_EN
      pause_d    = 1'b0;
`endif
    end
  end

  // Prescaler: mode restart beats a coincident wrap; the registered (old)
  // pause level gates counting, so the pausing edge itself still counts.
  always_comb begin
    ps_d   = ps_q;
    tick_d = 1'b0;
    if (press_q[BTN_MODE]) begin
      ps_d = '0;
    end else if (!pause_q) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        tick_d = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      press_q    <= '0;
      db_cnt_q   <= '0;
      ps_q       <= '0;
      tick_q     <= 1'b0;
      pause_q    <= 1'b0;
      mode_q     <= '0;
      mode_chg_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      acc_q      <= acc_d;
      press_q    <= press_d;
      db_cnt_q   <= db_cnt_d;
      ps_q       <= ps_d;
      tick_q     <= tick_d;
      pause_q    <= pause_d;
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  assign tick     = tick_q;
  assign pause    = pause_q;
  assign mode     = mode_q;
  assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_mode_tick_control.sv
// Bench for mode_tick_control with TICK_DIV=5, DEBOUNCE_CYCLES=4.
// Stimulus pushes expected tick edges, mode-change events and pause changes
// into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_mode_tick_control;

  localparam int T   = 5;
  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_pause = 1'b0;
  logic       tick, pause, mode_chg;
  logic [1:0] mode;

  mode_tick_control #(.TICK_DIV(T), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_pause(btn_pause),
    .tick     (tick),
    .pause    (pause),
    .mode     (mode),
    .mode_chg (mode_chg)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct { int e; logic [1:0] m; logic p; } chg_t;
  typedef struct { int e; logic v; } pev_t;

  int   tick_q[$];
  chg_t chg_q[$];
  pev_t pause_q[$];

  int tests = 0;
  int fails = 0;

  // Expected-tick schedule: ticks fall on base + k*T while not frozen
  int         base = 0, pushed = 0, frz = 0;
  bit         frozen = 0;
  logic [1:0] exp_mode = 2'b00;
  logic       exp_pause = 1'b0;
  bit         mon_en = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void sched_until(int lim);
    if (!frozen)
      for (int e = base + T; e <= lim; e += T)
        if (e > pushed) tick_q.push_back(e);
    if (lim > pushed) pushed = lim;
  endfunction

  function automatic void restart(int m);
    sched_until(m - 1);
    base = m;
    if (m > pushed) pushed = m;
    if (frozen) frz = m;
  endfunction

  function automatic void freeze(int p);
    sched_until(p);
    frozen = 1;
    frz = p;
  endfunction

  function automatic void unfreeze(int p);
    sched_until(p);
    frozen = 0;
    base += p - frz;
  endfunction

  task automatic run_to(int y);
    sched_until(y);
    while (edge_n < y) @(negedge clk);
  endtask

  // Press the selected buttons now, hold for 'hold' edges, then release
  task automatic press(bit dm, bit dp, int hold);
    int x, e;
    logic [1:0] nm;
    logic np;
    x = edge_n;
    if (dm) btn_mode = 1'b1;
    if (dp) btn_pause = 1'b1;
    e = x + LAT;
    run_to(e - 1);
    nm = dm ? exp_mode + 2'd1 : exp_mode;
    np = dp ? ~exp_pause : exp_pause;
`ifdef PAUSE_CLEAR_ON_MODE_EN
    if (dm) np = 1'b0;
`endif
    if (dm) begin
      restart(e);
      chg_q.push_back('{e, nm, np});
    end
    if (np != exp_pause) begin
      pause_q.push_back('{e, np});
      if (np) freeze(e);
      else unfreeze(e);
    end
    exp_mode  = nm;
    exp_pause = np;
    run_to(x + hold);
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    run_to(edge_n + LAT + 2);
  endtask

  task automatic press_at(int target, bit dm, bit dp, int hold);
    run_to(target - LAT);
    press(dm, dp, hold);
  endtask

  // Assert reset mid-cycle (clk stable), check outputs, release on a negedge
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("reset_tick", tick, 0);
    check("reset_pause", pause, 0);
    check("reset_mode", mode, 0);
    check("reset_mode_chg", mode_chg, 0);
    repeat (3) @(negedge clk);
    check("reset_hold_mode", mode, 0);
    reset     = 1'b1;
    base      = edge_n;
    pushed    = edge_n;
    frozen    = 0;
    exp_mode  = 2'b00;
    exp_pause = 1'b0;
    mon_en    = 1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  logic       prev_pause = 1'b0;
  logic [1:0] prev_mode  = 2'b00;
  always @(negedge clk) begin
    if (!mon_en || !reset) begin
      prev_pause = 1'b0;
      prev_mode  = 2'b00;
    end else begin
      if (tick === 1'b1) begin
        if (tick_q.size() == 0) check("tick_unexpected", edge_n, -1);
        else check("tick_edge", edge_n, tick_q.pop_front());
      end
      if (mode_chg === 1'b1) begin
        if (chg_q.size() == 0) begin
          check("mode_chg_unexpected", edge_n, -1);
        end else begin
          chg_t c;
          c = chg_q.pop_front();
          check("mode_chg_edge", edge_n, c.e);
          check("mode_value", mode, c.m);
          check("pause_at_mode_chg", pause, c.p);
        end
      end else if (mode !== prev_mode) begin
        check("mode_change_without_pulse", mode_chg, 1);
      end
      if (pause !== prev_pause) begin
        if (pause_q.size() == 0) begin
          check("pause_change_unexpected", edge_n, -1);
        end else begin
          pev_t p;
          p = pause_q.pop_front();
          check("pause_change_edge", edge_n, p.e);
          check("pause_value", pause, p.v);
        end
      end
      prev_pause = pause;
      prev_mode  = mode;
    end
  end

  initial begin
    int r, t0, k, pp, pr, w, x, seen;

    @(negedge clk);
    do_reset();
    r = edge_n;

    // Free-running ticks with a 3-cycle mode glitch that must be ignored
    run_to(r + 3);
    btn_mode = 1'b1;
    run_to(r + 6);
    btn_mode = 1'b0;
    run_to(r + 102);

    // Four mode presses: 01, 10, 11, back to 00
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 10);
    check("mode_after_wrap", mode, 0);

    // Pause with prescaler at 2, stay frozen over 100 cycles
    t0 = edge_n + LAT;
    k  = (base + 2 - t0) % T;
    if (k < 0) k += T;
    pp = t0 + k;
    press_at(pp, 1'b0, 1'b1, 10);
    run_to(pp + 100);
    check("paused_level", pause, 1);

    // Resume: first tick 3 edges after the resume edge
    x  = edge_n;
    btn_pause = 1'b1;
    pr = x + LAT;
    run_to(pr - 1);
    pause_q.push_back('{pr, 1'b0});
    unfreeze(pr);
    exp_pause = 1'b0;
    run_to(pr);
    sched_until(pr + 2 * T);
    seen = -1;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk);
      if (tick === 1'b1 && seen < 0) seen = edge_n;
    end
    check("resume_first_tick", seen, pr + 3);
    run_to(x + 10);
    btn_pause = 1'b0;
    run_to(edge_n + LAT + 2);

    // Mode event on the same edge as a prescaler wrap
    k = (edge_n + LAT - base + T - 1) / T;
    w = base + k * T;
    press_at(w, 1'b1, 1'b0, 10);

    // Both buttons together with pause=0
    press(1'b1, 1'b1, 10);
    if (exp_pause == 1'b0) press(1'b0, 1'b1, 10);

    // Reset mid-period and mid-debounce with mode=10, pause=1; mode button
    // stays held through reset release
    run_to(edge_n + 3);
    check("pre_reset_mode", mode, 2);
    check("pre_reset_pause", pause, 1);
    btn_mode = 1'b1;
    run_to(edge_n + 3);
    do_reset();
    r = edge_n;
    run_to(r + LAT - 1);
    restart(r + LAT);
    chg_q.push_back('{r + LAT, 2'b01, 1'b0});
    exp_mode = 2'b01;
    run_to(r + 12);
    btn_mode = 1'b0;
    run_to(edge_n + LAT + 2 + 2 * T);

    check("pending_ticks", tick_q.size(), 0);
    check("pending_mode_chg", chg_q.size(), 0);
    check("pending_pause", pause_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
